// File: rtl/cdb_arbiter.sv
// cdb_arbiter: N-to-M common-data-bus arbiter for the out-of-order backend.
//
// Each functional unit pushes completed results into its own small FIFO. A
// round-robin arbiter drains up to NUM_CDB FIFO heads per cycle onto the
// broadcast ports consumed by the RAT, ROB, PRF and reservation stations.
// The CDB has no backpressure. Every valid beat is consumed.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           backend flush; drops every buffered result
//   fu_valid/ready  per-FU push handshake
//   fu_rob_id, fu_rd_phy, fu_rd_arch, fu_rd_value
//                   packed per-FU payload, FU i at slice [i*W +: W]
//   cdb_valid       per-port broadcast valid
//   cdb_rob_id, cdb_rd_phy, cdb_rd_arch, cdb_rd_value
//                   packed per-port payload
//   cdb_src_fu      index of the FU that sourced each port
//
// Optional feature, enabled by defining CDB_ARB_STATS_EN:
//   stall_cnt       NUM_FU x 32 saturating counters of cycles with fu_valid && !fu_ready
//   bus_full_cnt    32-bit saturating counter of cycles in which every CDB port is valid
//   Both counters are cleared by rst only. Flush does not clear them.
module cdb_arbiter #(
  parameter int unsigned NUM_FU    = 4,
  parameter int unsigned NUM_CDB   = 2,
  parameter int unsigned BUF_DEPTH = 2,
  parameter int unsigned ROB_IDX_W = 5,
  parameter int unsigned PRF_IDX_W = 6,
  parameter int unsigned DATA_W    = 32,
  localparam int unsigned SrcW     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [NUM_FU-1:0]             fu_valid,
  output logic [NUM_FU-1:0]             fu_ready,
  input  logic [NUM_FU*ROB_IDX_W-1:0]   fu_rob_id,
  input  logic [NUM_FU*PRF_IDX_W-1:0]   fu_rd_phy,
  input  logic [NUM_FU*5-1:0]           fu_rd_arch,
  input  logic [NUM_FU*DATA_W-1:0]      fu_rd_value,
  output logic [NUM_CDB-1:0]            cdb_valid,
  output logic [NUM_CDB*ROB_IDX_W-1:0]  cdb_rob_id,
  output logic [NUM_CDB*PRF_IDX_W-1:0]  cdb_rd_phy,
  output logic [NUM_CDB*5-1:0]          cdb_rd_arch,
  output logic [NUM_CDB*DATA_W-1:0]     cdb_rd_value,
`ifdef CDB_ARB_STATS_EN
  output logic [NUM_FU*32-1:0]          stall_cnt,
  output logic [31:0]                   bus_full_cnt,
`endif
  output logic [NUM_CDB*SrcW-1:0]       cdb_src_fu
);

  localparam int unsigned ArchW = 5;
  localparam int unsigned PayW  = ROB_IDX_W + PRF_IDX_W + ArchW + DATA_W;
  localparam int unsigned PtrW  = $clog2(BUF_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(BUF_DEPTH);

  // Payload layout: {rob_id, rd_phy, rd_arch, rd_value}.
  logic [PayW-1:0] mem_q  [NUM_FU][BUF_DEPTH];
  logic [PtrW-1:0] wptr_q [NUM_FU];
  logic [PtrW-1:0] rptr_q [NUM_FU];
  logic [CntW-1:0] cnt_q  [NUM_FU];
  logic [SrcW-1:0] rr_q, rr_d;

  logic [PayW-1:0]   pay_in   [NUM_FU];
  logic [PayW-1:0]   head     [NUM_FU];
  logic [PayW-1:0]   port_pay [NUM_CDB];
  logic [SrcW-1:0]   port_fu  [NUM_CDB];
  logic [NUM_FU-1:0] push, pop, not_empty;
  logic              kill;

  // Reset and flush both freeze the handshake and the bus for the cycle.
  assign kill = rst | flush;

  // FIFO status, push handshake and head/payload views.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      pay_in[i] = {fu_rob_id[i*ROB_IDX_W +: ROB_IDX_W],
                   fu_rd_phy[i*PRF_IDX_W +: PRF_IDX_W],
                   fu_rd_arch[i*ArchW +: ArchW],
                   fu_rd_value[i*DATA_W +: DATA_W]};
      // Ready depends on count only, so a full FIFO refuses a push even while
      // it is being drained in the same cycle.
      fu_ready[i]  = (cnt_q[i] != FullCnt) && !kill;
      push[i]      = fu_valid[i] && fu_ready[i];
      not_empty[i] = (cnt_q[i] != '0);
      head[i]      = mem_q[i][rptr_q[i]];
    end
  end

  // Round-robin scan starting at rr_q. The n-th non-empty FIFO found takes
  // port n. Each FU appears once in the scan, so it gets at most one port.
  always_comb begin : arbitrate
    int unsigned n_grant;
    logic [SrcW:0] sum;
    logic [SrcW-1:0] fu_sel;
    n_grant   = 0;
    sum       = '0;
    fu_sel    = '0;
    pop       = '0;
    cdb_valid = '0;
    rr_d      = rr_q;
    for (int p = 0; p < NUM_CDB; p++) begin
      port_fu[p] = '0;
    end
    for (int off = 0; off < NUM_FU; off++) begin
      sum = {1'b0, rr_q} + (SrcW+1)'(off);
      if (sum >= (SrcW+1)'(NUM_FU)) begin
        sum = sum - (SrcW+1)'(NUM_FU);
      end
      fu_sel = sum[SrcW-1:0];
      if (!kill && not_empty[fu_sel] && (n_grant < NUM_CDB)) begin
        pop[fu_sel] = 1'b1;
        for (int p = 0; p < NUM_CDB; p++) begin
          if (n_grant == p) begin
            cdb_valid[p] = 1'b1;
            port_fu[p]   = fu_sel;
          end
        end
        // Pointer lands just past the last FU granted this cycle.
        rr_d    = (fu_sel == SrcW'(NUM_FU - 1)) ? '0 : fu_sel + SrcW'(1);
        n_grant = n_grant + 1;
      end
    end
  end

  // Drive granted heads onto the bus. Idle ports carry zeros.
  always_comb begin
    cdb_rob_id   = '0;
    cdb_rd_phy   = '0;
    cdb_rd_arch  = '0;
    cdb_rd_value = '0;
    cdb_src_fu   = '0;
    for (int p = 0; p < NUM_CDB; p++) begin
      port_pay[p] = cdb_valid[p] ? head[port_fu[p]] : '0;
      cdb_rob_id[p*ROB_IDX_W +: ROB_IDX_W] = port_pay[p][PayW-1 -: ROB_IDX_W];
      cdb_rd_phy[p*PRF_IDX_W +: PRF_IDX_W] = port_pay[p][DATA_W+ArchW +: PRF_IDX_W];
      cdb_rd_arch[p*ArchW +: ArchW]        = port_pay[p][DATA_W +: ArchW];
      cdb_rd_value[p*DATA_W +: DATA_W]     = port_pay[p][0 +: DATA_W];
      cdb_src_fu[p*SrcW +: SrcW]           = cdb_valid[p] ? port_fu[p] : '0;
    end
  end

  // FIFO pointers, counts and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < NUM_FU; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      rr_q <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (push[i]) begin
          wptr_q[i] <= wptr_q[i] + PtrW'(1);
        end
        if (pop[i]) begin
          rptr_q[i] <= rptr_q[i] + PtrW'(1);
        end
        unique case ({push[i], pop[i]})
          2'b10:   cnt_q[i] <= cnt_q[i] + CntW'(1);
          2'b01:   cnt_q[i] <= cnt_q[i] - CntW'(1);
          default: cnt_q[i] <= cnt_q[i];
        endcase
      end
      rr_q <= rr_d;
    end
  end

  // Storage needs no reset: the counts gate every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i]) begin
        mem_q[i][wptr_q[i]] <= pay_in[i];
      end
    end
  end

`ifdef CDB_ARB_STATS_EN
  logic [31:0] stall_q [NUM_FU];
  logic [31:0] bus_full_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_FU; i++) begin
        stall_q[i] <= '0;
      end
      bus_full_q <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (fu_valid[i] && !fu_ready[i] && (stall_q[i] != '1)) begin
          stall_q[i] <= stall_q[i] + 32'd1;
        end
      end
      if ((&cdb_valid) && (bus_full_q != '1)) begin
        bus_full_q <= bus_full_q + 32'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      stall_cnt[i*32 +: 32] = stall_q[i];
    end
  end

  assign bus_full_cnt = bus_full_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter (NUM_FU=4, NUM_CDB=2, BUF_DEPTH=2).
// A queue-based reference model predicts ready, grants and payloads each cycle.
// A hand-computed vector table and a few directed sequences pin down specific cases.
module tb_cdb_arbiter;
  localparam int NF = 4;
  localparam int NC = 2;
  localparam int D  = 2;
  localparam int RW = 5;
  localparam int PW = 6;
  localparam int DW = 32;

  typedef logic [47:0] pay_t;  // {rob_id, rd_phy, rd_arch, value}

  logic clk = 1'b0;
  logic rst, flush;
  logic [NF-1:0]    fu_valid, fu_ready;
  logic [NF*RW-1:0] fu_rob_id;
  logic [NF*PW-1:0] fu_rd_phy;
  logic [NF*5-1:0]  fu_rd_arch;
  logic [NF*DW-1:0] fu_rd_value;
  logic [NC-1:0]    cdb_valid;
  logic [NC*RW-1:0] cdb_rob_id;
  logic [NC*PW-1:0] cdb_rd_phy;
  logic [NC*5-1:0]  cdb_rd_arch;
  logic [NC*DW-1:0] cdb_rd_value;
  logic [NC*2-1:0]  cdb_src_fu;
`ifdef CDB_ARB_STATS_EN
  logic [NF*32-1:0] stall_cnt;
  logic [31:0]      bus_full_cnt;
  int unsigned      stall_m [NF];
  int unsigned      bus_m;
`endif

  pay_t in_pay [NF];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NF; i++) begin
      fu_rob_id[i*RW +: RW]   = in_pay[i][47:43];
      fu_rd_phy[i*PW +: PW]   = in_pay[i][42:37];
      fu_rd_arch[i*5 +: 5]    = in_pay[i][36:32];
      fu_rd_value[i*DW +: DW] = in_pay[i][31:0];
    end
  end

  cdb_arbiter #(
    .NUM_FU(NF), .NUM_CDB(NC), .BUF_DEPTH(D),
    .ROB_IDX_W(RW), .PRF_IDX_W(PW), .DATA_W(DW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fu_valid(fu_valid), .fu_ready(fu_ready),
    .fu_rob_id(fu_rob_id), .fu_rd_phy(fu_rd_phy),
    .fu_rd_arch(fu_rd_arch), .fu_rd_value(fu_rd_value),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
    .cdb_rd_phy(cdb_rd_phy), .cdb_rd_arch(cdb_rd_arch),
    .cdb_rd_value(cdb_rd_value),
`ifdef CDB_ARB_STATS_EN
    .stall_cnt(stall_cnt), .bus_full_cnt(bus_full_cnt),
`endif
    .cdb_src_fu(cdb_src_fu)
  );

  // Reference model state.
  pay_t mq [NF][$];
  int   rr_m;
  logic [NF-1:0] exp_ready;
  logic [NC-1:0] exp_cv;
  int   gsrc [NC];
  int   ng;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic pay_t rand_pay();
    return pay_t'({$urandom(), $urandom()});
  endfunction

  task automatic randomize_payloads();
    for (int i = 0; i < NF; i++) in_pay[i] = rand_pay();
  endtask

  // Expected outputs for the current inputs and model state.
  task automatic model_eval();
    ng     = 0;
    exp_cv = '0;
    for (int i = 0; i < NF; i++)
      exp_ready[i] = !rst && !flush && (mq[i].size() < D);
    if (!rst && !flush) begin
      for (int off = 0; off < NF; off++) begin
        int idx;
        idx = (rr_m + off) % NF;
        if (mq[idx].size() > 0 && ng < NC) begin
          gsrc[ng]   = idx;
          exp_cv[ng] = 1'b1;
          ng++;
        end
      end
    end
  endtask

  task automatic model_step();
`ifdef CDB_ARB_STATS_EN
    for (int i = 0; i < NF; i++) begin
      if (rst) stall_m[i] = 0;
      else if (fu_valid[i] && !exp_ready[i] && stall_m[i] != 32'hffff_ffff) stall_m[i]++;
    end
    if (rst) bus_m = 0;
    else if ((&exp_cv) && bus_m != 32'hffff_ffff) bus_m++;
`endif
    if (rst || flush) begin
      for (int i = 0; i < NF; i++) mq[i].delete();
      rr_m = 0;
    end else begin
      for (int k = 0; k < ng; k++) void'(mq[gsrc[k]].pop_front());
      if (ng > 0) rr_m = (gsrc[ng-1] + 1) % NF;
      for (int i = 0; i < NF; i++)
        if (fu_valid[i] && exp_ready[i]) mq[i].push_back(in_pay[i]);
    end
  endtask

  // Sample at the falling edge and compare against the model.
  task automatic sample(input string tag);
    @(negedge clk);
    model_eval();
    check({tag, " ready"}, 64'(fu_ready), 64'(exp_ready));
    check({tag, " cdb_valid"}, 64'(cdb_valid), 64'(exp_cv));
    for (int k = 0; k < NC; k++) begin
      if (exp_cv[k]) begin
        check($sformatf("%s port%0d src+payload", tag, k),
              64'({cdb_src_fu[k*2 +: 2], cdb_rob_id[k*RW +: RW], cdb_rd_phy[k*PW +: PW],
                   cdb_rd_arch[k*5 +: 5], cdb_rd_value[k*DW +: DW]}),
              64'({2'(gsrc[k]), mq[gsrc[k]][0]}));
      end
    end
`ifdef CDB_ARB_STATS_EN
    for (int i = 0; i < NF; i++)
      check($sformatf("%s stall_cnt%0d", tag, i), 64'(stall_cnt[i*32 +: 32]), 64'(stall_m[i]));
    check({tag, " bus_full_cnt"}, 64'(bus_full_cnt), 64'(bus_m));
`endif
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    logic       r;
    logic       f;
    logic [3:0] v;
    logic [3:0] rdy;
    logic [1:0] cv;
    logic [1:0] s0;
    logic [1:0] s1;
  } vec_t;

  vec_t vt [16];

  initial begin
    // Hand-derived expectations, starting from an empty arbiter with rr_ptr=0.
    vt[0]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 2'b00, 2'd0, 2'd0};  // in reset
    vt[1]  = '{1'b0, 1'b0, 4'b1111, 4'b1111, 2'b00, 2'd0, 2'd0};  // all push
    vt[2]  = '{1'b0, 1'b0, 4'b0000, 4'b1111, 2'b11, 2'd0, 2'd1};  // FU0, FU1
    vt[3]  = '{1'b0, 1'b0, 4'b0000, 4'b1111, 2'b11, 2'd2, 2'd3};  // FU2, FU3, rr->0
    vt[4]  = '{1'b0, 1'b0, 4'b0010, 4'b1111, 2'b00, 2'd0, 2'd0};  // FU1 push
    vt[5]  = '{1'b0, 1'b0, 4'b0000, 4'b1111, 2'b01, 2'd1, 2'd0};  // FU1 out, rr->2
    vt[6]  = '{1'b0, 1'b0, 4'b0100, 4'b1111, 2'b00, 2'd0, 2'd0};
    vt[7]  = '{1'b0, 1'b0, 4'b0100, 4'b1111, 2'b01, 2'd2, 2'd0};  // rr->3
    vt[8]  = '{1'b0, 1'b0, 4'b1011, 4'b1111, 2'b01, 2'd2, 2'd0};
    vt[9]  = '{1'b0, 1'b0, 4'b1011, 4'b1111, 2'b11, 2'd3, 2'd0};  // wrap, rr->1
    vt[10] = '{1'b0, 1'b0, 4'b0010, 4'b1101, 2'b11, 2'd1, 2'd3};  // FU1 full
    vt[11] = '{1'b0, 1'b1, 4'b1111, 4'b0000, 2'b00, 2'd0, 2'd0};  // flush
    vt[12] = '{1'b0, 1'b0, 4'b0000, 4'b1111, 2'b00, 2'd0, 2'd0};  // nothing survives
    vt[13] = '{1'b0, 1'b0, 4'b1000, 4'b1111, 2'b00, 2'd0, 2'd0};
    vt[14] = '{1'b1, 1'b0, 4'b0001, 4'b0000, 2'b00, 2'd0, 2'd0};  // reset mid-traffic
    vt[15] = '{1'b0, 1'b0, 4'b0000, 4'b1111, 2'b00, 2'd0, 2'd0};

    rr_m = 0;
`ifdef CDB_ARB_STATS_EN
    for (int i = 0; i < NF; i++) stall_m[i] = 0;
    bus_m = 0;
`endif
    rst = 1'b1; flush = 1'b0; fu_valid = '0;
    randomize_payloads();
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Table-driven vectors.
    for (int n = 0; n < 16; n++) begin
      rst      = vt[n].r;
      flush    = vt[n].f;
      fu_valid = vt[n].v;
      randomize_payloads();
      sample($sformatf("vec%0d", n));
      check($sformatf("vec%0d tbl ready", n), 64'(fu_ready), 64'(vt[n].rdy));
      check($sformatf("vec%0d tbl cdb_valid", n), 64'(cdb_valid), 64'(vt[n].cv));
      if (vt[n].cv[0]) check($sformatf("vec%0d tbl src0", n), 64'(cdb_src_fu[1:0]), 64'(vt[n].s0));
      if (vt[n].cv[1]) check($sformatf("vec%0d tbl src1", n), 64'(cdb_src_fu[3:2]), 64'(vt[n].s1));
      advance();
    end

    // Single result from FU1 appears on port 0 one cycle later.
    in_pay[1] = {5'd3, 6'd12, 5'd7, 32'hDEAD_BEEF};
    fu_valid  = 4'b0010;
    sample("single push");
    advance();
    fu_valid = 4'b0000;
    sample("single out");
    check("single cdb_valid", 64'(cdb_valid), 64'(2'b01));
    check("single src", 64'(cdb_src_fu[1:0]), 64'd1);
    check("single rob_id", 64'(cdb_rob_id[4:0]), 64'd3);
    check("single rd_phy", 64'(cdb_rd_phy[5:0]), 64'd12);
    check("single value", 64'(cdb_rd_value[31:0]), 64'hDEAD_BEEF);
    advance();

    // Backpressure: FU2 pushes three back-to-back while FU0/FU1 compete.
    rst = 1'b1; fu_valid = '0;
    sample("bp reset");
    advance();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      fu_valid = (c < 4) ? 4'b0111 : 4'b0000;
      if (c == 3) fu_valid = 4'b0100;
      randomize_payloads();
      sample($sformatf("bp c%0d", c));
      if (c == 2) check("bp full ready", 64'(fu_ready), 64'(4'b1011));
      if (c == 3) check("bp drained ready", 64'(fu_ready), 64'(4'b1101));
      advance();
    end

    // Randomized traffic with occasional flush and reset.
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 149) == 0);
      flush = ($urandom_range(0, 29) == 0);
      for (int i = 0; i < NF; i++) fu_valid[i] = ($urandom_range(0, 3) != 0);
      randomize_payloads();
      sample($sformatf("rand%0d", c));
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
